echo_mix_fsm: RTL and testbench

Echo/feedback mixer stage placed directly around the variable audio delay line.
- Combines the dry sample with the delayed (wet) sample from the delay line into the effect output.
- Produces the feedback sample that is written back into the delay line input.
- Uses one shared signed multiplier, sequenced by a small FSM; one computation per sample strobe.

---
 rtl/echo_pkg.sv | 22 ++
 rtl/sat_narrow.sv | 37 +++
 rtl/echo_mix_fsm.sv | 139 +++++++++++++
 tb/tb_echo_mix_fsm.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/echo_pkg.sv
// Shared definitions for the echo/feedback mixer: default widths, gain unity,
// saturation limits and the sequencing state encoding.
package echo_pkg;

   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_GAIN_WIDTH = 8;
   localparam int DEF_GAIN_FRAC  = 7;

   // Q1.7 gain value that passes a sample through unchanged
   localparam int GAIN_UNITY = 1 << DEF_GAIN_FRAC;

   localparam int SAT_MAX = (1 << (DEF_DATA_WIDTH - 1)) - 1;
   localparam int SAT_MIN = -(1 << (DEF_DATA_WIDTH - 1));

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DRY  = 2'd1,
      ST_WET  = 2'd2,
      ST_FB   = 2'd3
   } state_t;

endpackage

// File: rtl/sat_narrow.sv
// Arithmetic right shift (floor) of a wide signed value followed by a clamp
// to the narrow signed output range, with a flag when the clamp engaged.
module sat_narrow
   import echo_pkg::*;
#(
   parameter int IN_WIDTH  = DEF_DATA_WIDTH + DEF_GAIN_WIDTH + 2,
   parameter int OUT_WIDTH = DEF_DATA_WIDTH,
   parameter int SHIFT     = DEF_GAIN_FRAC
) (
   input  logic signed [IN_WIDTH-1:0]  value,
   output logic signed [OUT_WIDTH-1:0] result,
   output logic                        saturated
);

   // Output range limits expressed at the wide width so the compare is exact
   localparam logic signed [IN_WIDTH-1:0] MAX_W =
      {{(IN_WIDTH - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
   localparam logic signed [IN_WIDTH-1:0] MIN_W =
      {{(IN_WIDTH - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

   logic signed [IN_WIDTH-1:0] shifted;

   // NOTE: every output gets a default first so no path through the block can infer a latch.
   always_comb begin
      shifted   = value >>> SHIFT;
      result    = shifted[OUT_WIDTH-1:0];
      saturated = 1'b0;
      if (shifted > MAX_W) begin
         result    = MAX_W[OUT_WIDTH-1:0];
         saturated = 1'b1;
      end else if (shifted < MIN_W) begin
         result    = MIN_W[OUT_WIDTH-1:0];
         saturated = 1'b1;
      end
   end

endmodule

// File: rtl/echo_mix_fsm.sv
// Echo/feedback mixer around the delay line: one shared signed multiplier
// sequenced over DRY, WET and FB steps for each accepted sample strobe.
module echo_mix_fsm
   import echo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int GAIN_WIDTH = DEF_GAIN_WIDTH,
   parameter int GAIN_FRAC  = DEF_GAIN_FRAC
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         sample_valid,
   input  logic signed [DATA_WIDTH-1:0] dry_in,
   input  logic signed [DATA_WIDTH-1:0] wet_in,
   input  logic        [GAIN_WIDTH-1:0] dry_gain,
   input  logic        [GAIN_WIDTH-1:0] wet_gain,
   input  logic        [GAIN_WIDTH-1:0] fb_gain,
   output logic signed [DATA_WIDTH-1:0] mix_out,
   output logic signed [DATA_WIDTH-1:0] fb_out,
   output logic                         out_valid,
   output logic                         busy,
   output logic                         sat,
   output logic                         overrun
);

   localparam int PROD_W = DATA_WIDTH + GAIN_WIDTH + 1;
   localparam int ACC_W  = PROD_W + 1;

   state_t                       state;
   logic signed [DATA_WIDTH-1:0] dry_q;
   logic signed [DATA_WIDTH-1:0] wet_q;
   logic        [GAIN_WIDTH-1:0] dry_gain_q;
   logic        [GAIN_WIDTH-1:0] wet_gain_q;
   logic        [GAIN_WIDTH-1:0] fb_gain_q;
   logic signed [ACC_W-1:0]      acc;

   logic signed [DATA_WIDTH-1:0] mul_sample;
   logic        [GAIN_WIDTH-1:0] mul_gain;
   logic signed [PROD_W-1:0]     product;
   logic signed [ACC_W-1:0]      fb_wide;
   logic signed [DATA_WIDTH-1:0] mix_res;
   logic signed [DATA_WIDTH-1:0] fb_res;
   logic                         mix_sat;
   logic                         fb_sat;

   // Operand select for the single multiplier; FB reuses the wet sample
   always_comb begin
      mul_sample = wet_q;
      mul_gain   = fb_gain_q;
      case (state)
         ST_DRY: begin
            mul_sample = dry_q;
            mul_gain   = dry_gain_q;
         end
         ST_WET: mul_gain = wet_gain_q;
         default: ;
      endcase
      product = PROD_W'(mul_sample) * PROD_W'($signed({1'b0, mul_gain}));
   end

   // Pre-scaling dry by the gain unity lets one shared shift give dry + floor(wet*fbg)
   assign fb_wide = (ACC_W'(dry_q) <<< GAIN_FRAC) + ACC_W'(product);

   sat_narrow #(
      .IN_WIDTH  (ACC_W),
      .OUT_WIDTH (DATA_WIDTH),
      .SHIFT     (GAIN_FRAC)
   ) u_mix_sat (
      .value     (acc),
      .result    (mix_res),
      .saturated (mix_sat)
   );

   sat_narrow #(
      .IN_WIDTH  (ACC_W),
      .OUT_WIDTH (DATA_WIDTH),
      .SHIFT     (GAIN_FRAC)
   ) u_fb_sat (
      .value     (fb_wide),
      .result    (fb_res),
      .saturated (fb_sat)
   );

   assign busy = (state != ST_IDLE);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the sample/gain holding registers are reset too, since they are few flops, not a memory.
         state      <= ST_IDLE;
         dry_q      <= '0;
         wet_q      <= '0;
         dry_gain_q <= '0;
         wet_gain_q <= '0;
         fb_gain_q  <= '0;
         acc        <= '0;
         mix_out    <= '0;
         fb_out     <= '0;
         out_valid  <= 1'b0;
         sat        <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         sat       <= 1'b0;
         if (sample_valid && (state != ST_IDLE)) begin
            overrun <= 1'b1;
         end
         case (state)
            ST_IDLE: begin
               if (sample_valid) begin
                  dry_q      <= dry_in;
                  wet_q      <= wet_in;
                  dry_gain_q <= dry_gain;
                  wet_gain_q <= wet_gain;
                  fb_gain_q  <= fb_gain;
                  state      <= ST_DRY;
               end
            end
            ST_DRY: begin
               acc   <= ACC_W'(product);
               state <= ST_WET;
            end
            ST_WET: begin
               acc   <= acc + ACC_W'(product);
               state <= ST_FB;
            end
            ST_FB: begin
               mix_out   <= mix_res;
               fb_out    <= fb_res;
               out_valid <= 1'b1;
               sat       <= mix_sat | fb_sat;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_echo_mix_fsm.sv
// Self-checking bench for echo_mix_fsm: directed and randomized samples scored
// against an arithmetic reference model of the mixer.
module tb_echo_mix_fsm;

   logic               clk;
   logic               rst_n;
   logic               sample_valid;
   logic signed [15:0] dry_in;
   logic signed [15:0] wet_in;
   logic        [7:0]  dry_gain;
   logic        [7:0]  wet_gain;
   logic        [7:0]  fb_gain;
   logic signed [15:0] mix_out;
   logic signed [15:0] fb_out;
   logic               out_valid;
   logic               busy;
   logic               sat;
   logic               overrun;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int cyc;
      int mix;
      int fb;
      bit s;
   } pulse_t;

   pulse_t exp_q[$];
   pulse_t obs_q[$];
   bit     strobe_at[64];

   echo_mix_fsm dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sample_valid (sample_valid),
      .dry_in       (dry_in),
      .wet_in       (wet_in),
      .dry_gain     (dry_gain),
      .wet_gain     (wet_gain),
      .fb_gain      (fb_gain),
      .mix_out      (mix_out),
      .fb_out       (fb_out),
      .out_valid    (out_valid),
      .busy         (busy),
      .sat          (sat),
      .overrun      (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic longint floor_div(longint a, longint b);
      longint q = a / b;
      if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
      return q;
   endfunction

   function automatic longint clamp16(longint v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   function automatic pulse_t model(int cyc, int d, int w, int dg, int wg, int fg);
      pulse_t p;
      longint m_raw = floor_div(longint'(d) * dg + longint'(w) * wg, 128);
      longint f_raw = longint'(d) + floor_div(longint'(w) * fg, 128);
      p.cyc = cyc;
      p.mix = int'(clamp16(m_raw));
      p.fb  = int'(clamp16(f_raw));
      p.s   = (clamp16(m_raw) != m_raw) || (clamp16(f_raw) != f_raw);
      return p;
   endfunction

   function automatic int rand_sample();
      logic signed [15:0] t = 16'($urandom);
      return int'(t);
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic scramble_inputs();
      dry_in   = 16'($urandom);
      wet_in   = 16'($urandom);
      dry_gain = 8'($urandom);
      wet_gain = 8'($urandom);
      fb_gain  = 8'($urandom);
   endtask

   // One sample from idle; reports the first pulse seen within 6 edges after capture
   task automatic do_sample(input int d, input int w, input int dg, input int wg, input int fg,
                            output int m, output int f, output bit s,
                            output int lat, output int pulses);
      @(negedge clk);
      dry_in       = 16'(d);
      wet_in       = 16'(w);
      dry_gain     = 8'(dg);
      wet_gain     = 8'(wg);
      fb_gain      = 8'(fg);
      sample_valid = 1'b1;
      @(posedge clk);
      #1;
      sample_valid = 1'b0;
      scramble_inputs();
      lat = -1; pulses = 0; m = 0; f = 0; s = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk);
         #1;
         if (out_valid) begin
            pulses++;
            if (lat < 0) begin
               lat = k; m = int'(mix_out); f = int'(fb_out); s = sat;
            end
         end
      end
   endtask

   // Cycle-by-cycle stream; a strobe is accepted only if 4+ edges after the last accepted one
   task automatic run_stream(input int n_cyc);
      int next_free = 0;
      int d, w, dg, wg, fg;
      exp_q.delete();
      obs_q.delete();
      for (int c = 0; c < n_cyc; c++) begin
         @(negedge clk);
         d  = rand_sample();
         w  = rand_sample();
         dg = int'($urandom_range(0, 255));
         wg = int'($urandom_range(0, 255));
         fg = int'($urandom_range(0, 255));
         dry_in = 16'(d); wet_in = 16'(w);
         dry_gain = 8'(dg); wet_gain = 8'(wg); fb_gain = 8'(fg);
         sample_valid = strobe_at[c];
         if (strobe_at[c] && c >= next_free) begin
            exp_q.push_back(model(c + 3, d, w, dg, wg, fg));
            next_free = c + 4;
         end
         @(posedge clk);
         #1;
         if (out_valid) obs_q.push_back('{c, int'(mix_out), int'(fb_out), sat});
      end
      @(negedge clk);
      sample_valid = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      sample_valid = 1'b0;
      scramble_inputs();
      #23;
      checks++; if (mix_out !== 16'sd0) begin errors++; $display("FAIL reset_mix_out: got %0d expected 0", mix_out); end
      checks++; if (fb_out !== 16'sd0) begin errors++; $display("FAIL reset_fb_out: got %0d expected 0", fb_out); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (sat !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b expected 0", sat); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_unity();
      int m, f, lat, pulses; bit s;
      do_sample(1000, 0, 128, 64, 64, m, f, s, lat, pulses);
      checks++; if (lat !== 3) begin errors++; $display("FAIL unity_latency: got %0d expected 3", lat); end
      checks++; if (pulses !== 1) begin errors++; $display("FAIL unity_pulses: got %0d expected 1", pulses); end
      checks++; if (m !== 1000) begin errors++; $display("FAIL unity_mix: got %0d expected 1000", m); end
      checks++; if (f !== 1000) begin errors++; $display("FAIL unity_fb: got %0d expected 1000", f); end
      checks++; if (s !== 1'b0) begin errors++; $display("FAIL unity_sat: got %b expected 0", s); end
      checks++; if (mix_out !== 16'sd1000) begin errors++; $display("FAIL unity_hold: got %0d expected 1000", mix_out); end
   endtask

   task automatic test_echo();
      int m, f, lat, pulses; bit s;
      do_sample(1000, 2000, 128, 64, 64, m, f, s, lat, pulses);
      checks++; if (m !== 2000) begin errors++; $display("FAIL echo_mix: got %0d expected 2000", m); end
      checks++; if (f !== 2000) begin errors++; $display("FAIL echo_fb: got %0d expected 2000", f); end
      do_sample(-1, 0, 64, 64, 64, m, f, s, lat, pulses);
      checks++; if (m !== -1) begin errors++; $display("FAIL floor_mix: got %0d expected -1", m); end
      checks++; if (f !== -1) begin errors++; $display("FAIL floor_fb: got %0d expected -1", f); end
      do_sample(12345, -20000, 0, 128, 0, m, f, s, lat, pulses);
      checks++; if (m !== -20000) begin errors++; $display("FAIL gain0_mix: got %0d expected -20000", m); end
      checks++; if (f !== 12345) begin errors++; $display("FAIL gain0_fb: got %0d expected 12345", f); end
   endtask

   task automatic test_saturation();
      int m, f, lat, pulses; bit s;
      do_sample(30000, 30000, 128, 128, 128, m, f, s, lat, pulses);
      checks++; if (m !== 32767) begin errors++; $display("FAIL sat_pos_mix: got %0d expected 32767", m); end
      checks++; if (f !== 32767) begin errors++; $display("FAIL sat_pos_fb: got %0d expected 32767", f); end
      checks++; if (s !== 1'b1) begin errors++; $display("FAIL sat_pos_flag: got %b expected 1", s); end
      do_sample(-30000, -30000, 128, 128, 128, m, f, s, lat, pulses);
      checks++; if (m !== -32768) begin errors++; $display("FAIL sat_neg_mix: got %0d expected -32768", m); end
      checks++; if (f !== -32768) begin errors++; $display("FAIL sat_neg_fb: got %0d expected -32768", f); end
      checks++; if (s !== 1'b1) begin errors++; $display("FAIL sat_neg_flag: got %b expected 1", s); end
      @(posedge clk); #1;
      checks++; if (sat !== 1'b0) begin errors++; $display("FAIL sat_clears: got %b expected 0", sat); end
   endtask

   task automatic test_random();
      int m, f, lat, pulses; bit s;
      int d, w, dg, wg, fg;
      pulse_t e;
      for (int i = 0; i < 24; i++) begin
         d  = (i % 4 == 0) ? ((i % 8 == 0) ? 32767 : -32768) : rand_sample();
         w  = (i % 6 == 1) ? -32768 : rand_sample();
         dg = (i % 5 == 0) ? 0 : ((i % 5 == 1) ? 255 : int'($urandom_range(0, 255)));
         wg = (i % 7 == 0) ? 0 : int'($urandom_range(0, 255));
         fg = (i % 3 == 0) ? 255 : int'($urandom_range(0, 255));
         e  = model(0, d, w, dg, wg, fg);
         do_sample(d, w, dg, wg, fg, m, f, s, lat, pulses);
         checks++; if (lat !== 3 || pulses !== 1) begin errors++; $display("FAIL rand%0d_timing: got lat=%0d pulses=%0d expected lat=3 pulses=1", i, lat, pulses); end
         checks++; if (m !== e.mix) begin errors++; $display("FAIL rand%0d_mix: got %0d expected %0d", i, m, e.mix); end
         checks++; if (f !== e.fb) begin errors++; $display("FAIL rand%0d_fb: got %0d expected %0d", i, f, e.fb); end
         checks++; if (s !== e.s) begin errors++; $display("FAIL rand%0d_sat: got %b expected %b", i, s, e.s); end
      end
   endtask

   task automatic test_back_to_back();
      foreach (strobe_at[i]) strobe_at[i] = 1'b0;
      for (int i = 0; i < 8; i++) strobe_at[4 * i] = 1'b1;
      run_stream(36);
      checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] != exp_q[i]) begin
            errors++;
            $display("FAIL b2b_pulse%0d: got cyc=%0d mix=%0d fb=%0d sat=%b expected cyc=%0d mix=%0d fb=%0d sat=%b",
                     i, obs_q[i].cyc, obs_q[i].mix, obs_q[i].fb, obs_q[i].s,
                     exp_q[i].cyc, exp_q[i].mix, exp_q[i].fb, exp_q[i].s);
         end
      end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b expected 0", overrun); end
   endtask

   task automatic test_overrun();
      foreach (strobe_at[i]) strobe_at[i] = 1'b0;
      strobe_at[0] = 1'b1; strobe_at[2] = 1'b1; strobe_at[4] = 1'b1;
      strobe_at[7] = 1'b1; strobe_at[8] = 1'b1;
      run_stream(14);
      checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL ovr_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] != exp_q[i]) begin
            errors++;
            $display("FAIL ovr_pulse%0d: got cyc=%0d mix=%0d fb=%0d sat=%b expected cyc=%0d mix=%0d fb=%0d sat=%b",
                     i, obs_q[i].cyc, obs_q[i].mix, obs_q[i].fb, obs_q[i].s,
                     exp_q[i].cyc, exp_q[i].mix, exp_q[i].fb, exp_q[i].s);
         end
      end
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b expected 1", overrun); end
      repeat (5) @(posedge clk);
      #1;
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
   endtask

   task automatic test_reset_mid();
      int m, f, lat, pulses; bit s;
      pulse_t e;
      do_sample(1234, 0, 128, 0, 0, m, f, s, lat, pulses);
      checks++; if (mix_out !== 16'sd1234) begin errors++; $display("FAIL rstmid_pre: got %0d expected 1234", mix_out); end
      @(negedge clk);
      dry_in = 16'sd5000; wet_in = 16'sd7000;
      dry_gain = 8'd100; wet_gain = 8'd90; fb_gain = 8'd80;
      sample_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      sample_valid = 1'b0;
      @(posedge clk);
      #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b expected 1", busy); end
      rst_n = 1'b0;
      #1;
      checks++; if (mix_out !== 16'sd0 || fb_out !== 16'sd0) begin errors++; $display("FAIL rstmid_outputs: got mix=%0d fb=%0d expected 0 0", mix_out, fb_out); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rstmid_overrun: got %b expected 0", overrun); end
      pulses = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (out_valid) pulses++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) begin
         @(posedge clk); #1;
         if (out_valid) pulses++;
      end
      checks++; if (pulses !== 0) begin errors++; $display("FAIL rstmid_no_pulse: got %0d pulses expected 0", pulses); end
      e = model(0, -7, 300, 200, 100, 255);
      do_sample(-7, 300, 200, 100, 255, m, f, s, lat, pulses);
      checks++; if (lat !== 3 || pulses !== 1) begin errors++; $display("FAIL rstmid_after_timing: got lat=%0d pulses=%0d expected 3 1", lat, pulses); end
      checks++; if (m !== e.mix || f !== e.fb) begin errors++; $display("FAIL rstmid_after_values: got mix=%0d fb=%0d expected %0d %0d", m, f, e.mix, e.fb); end
   endtask

   initial begin
      test_reset();
      test_unity();
      test_echo();
      test_saturation();
      test_random();
      test_back_to_back();
      test_overrun();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
